// File: rtl/edge_pulse_pkg.sv
// Shared constants and helpers for the edge pulse generator.
// Optional edge counters are enabled with PULSE_GEN_EDGE_CNT_EN.
package edge_pulse_pkg;

  localparam int EDGE_CNT_W      = 8;
  localparam int SYNC_STAGES_MAX = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/edge_pulse_chan.sv
// One channel: input synchroniser, glitch filter, stretched edge pulses.
// Saturating edge counter is present only when PULSE_GEN_EDGE_CNT_EN is defined.
module edge_pulse_chan
  import edge_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int STRETCH     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pos_pulse,
  output logic neg_pulse
`ifdef PULSE_GEN_EDGE_CNT_EN
  ,
  input  logic                  clr,
  output logic [EDGE_CNT_W-1:0] edge_cnt
`endif
);

  localparam int FC_W = (clog2(FILTER_LEN) < 1) ? 1 : clog2(FILTER_LEN);
  localparam int PC_W = (clog2(STRETCH + 1) < 1) ? 1 : clog2(STRETCH + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);
  localparam logic [PC_W-1:0] PC_LOAD = PC_W'(STRETCH);

  logic s;

  // Stage p0: synchroniser chain (bypassed entirely when SYNC_STAGES is 0)
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = raw;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_p0;
      logic [SYNC_STAGES:0]   sync_nxt;
      assign sync_nxt = {sync_p0, raw};
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_p0 <= '0;
        else        sync_p0 <= sync_nxt[SYNC_STAGES-1:0];
      end
      assign s = sync_p0[SYNC_STAGES-1];
    end
  endgenerate

  // Stage p1: glitch filter, accepted level and stretch counters
  logic [FC_W-1:0] fc_p1;
  logic            level_p1;
  logic [PC_W-1:0] pc_p1;
  logic [PC_W-1:0] nc_p1;
  logic            rise;
  logic            fall;

  always_comb begin
    rise = 1'b0;
    fall = 1'b0;
    if ((s != level_p1) && (fc_p1 == FC_LAST)) begin
      rise = s;
      fall = !s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_p1    <= '0;
      level_p1 <= 1'b0;
    end else if (s == level_p1) begin
      fc_p1 <= '0;
    end else if (fc_p1 == FC_LAST) begin
      level_p1 <= s;
      fc_p1    <= '0;
    end else begin
      fc_p1 <= fc_p1 + FC_W'(1);
    end
  end

  // A new event reloads its counter outright, so retriggers extend the pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p1 <= '0;
      nc_p1 <= '0;
    end else begin
      if (rise)             pc_p1 <= PC_LOAD;
      else if (pc_p1 != '0) pc_p1 <= pc_p1 - PC_W'(1);
      if (fall)             nc_p1 <= PC_LOAD;
      else if (nc_p1 != '0) nc_p1 <= nc_p1 - PC_W'(1);
    end
  end

  assign level     = level_p1;
  assign pos_pulse = (pc_p1 != '0);
  assign neg_pulse = (nc_p1 != '0);

`ifdef PULSE_GEN_EDGE_CNT_EN
  logic [EDGE_CNT_W-1:0] cnt_p1;

  // Clear wins over a same-cycle edge; the count sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            cnt_p1 <= '0;
    else if (clr)                          cnt_p1 <= '0;
    else if ((rise || fall) && cnt_p1 != '1) cnt_p1 <= cnt_p1 + EDGE_CNT_W'(1);
  end

  assign edge_cnt = cnt_p1;
`endif

endmodule

// File: rtl/edge_pulse_gen.sv
// NUM independent filtered-level / edge-pulse channels.
// Define PULSE_GEN_EDGE_CNT_EN to add clr_I and per-channel 8-bit edge counters.
module edge_pulse_gen
  import edge_pulse_pkg::*;
#(
  parameter int NUM         = 3,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int STRETCH     = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NUM-1:0] in,
  output logic [NUM-1:0] level_O,
  output logic [NUM-1:0] toggle_O,
  output logic [NUM-1:0] posedge_O,
  output logic [NUM-1:0] negedge_O
`ifdef PULSE_GEN_EDGE_CNT_EN
  ,
  input  logic                      clr_I,
  output logic [NUM*EDGE_CNT_W-1:0] edge_cnt_O
`endif
);

  generate
    if (NUM < 1 || SYNC_STAGES < 0 || SYNC_STAGES > SYNC_STAGES_MAX ||
        FILTER_LEN < 1 || STRETCH < 1) begin : g_bad_param
      $error("edge_pulse_gen: illegal parameter combination");
    end

    for (genvar i = 0; i < NUM; i++) begin : g_chan
      edge_pulse_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN),
        .STRETCH     (STRETCH)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw       (in[i]),
        .level     (level_O[i]),
        .pos_pulse (posedge_O[i]),
        .neg_pulse (negedge_O[i])
`ifdef PULSE_GEN_EDGE_CNT_EN
        ,
        .clr       (clr_I),
        .edge_cnt  (edge_cnt_O[i*EDGE_CNT_W +: EDGE_CNT_W])
`endif
      );
    end
  endgenerate

  assign toggle_O = posedge_O | negedge_O;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Bench for edge_pulse_gen: a default instance and a SYNC 0 / FILTER 1 / STRETCH 4 instance.
// Counter checks are included when PULSE_GEN_EDGE_CNT_EN is defined.
module tb_edge_pulse_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] in_a, in_b;
  logic [2:0] lvl_a, tog_a, pos_a, neg_a;
  logic [2:0] lvl_b, tog_b, pos_b, neg_b;
  logic       clr_a, clr_b;
`ifdef PULSE_GEN_EDGE_CNT_EN
  logic [23:0] cnt_a, cnt_b;
`endif

  int total = 0;
  int bad   = 0;

  edge_pulse_gen #(.NUM(3), .SYNC_STAGES(2), .FILTER_LEN(3), .STRETCH(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a),
    .level_O(lvl_a), .toggle_O(tog_a), .posedge_O(pos_a), .negedge_O(neg_a)
`ifdef PULSE_GEN_EDGE_CNT_EN
    , .clr_I(clr_a), .edge_cnt_O(cnt_a)
`endif
  );

  edge_pulse_gen #(.NUM(3), .SYNC_STAGES(0), .FILTER_LEN(1), .STRETCH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_b),
    .level_O(lvl_b), .toggle_O(tog_b), .posedge_O(pos_b), .negedge_O(neg_b)
`ifdef PULSE_GEN_EDGE_CNT_EN
    , .clr_I(clr_b), .edge_cnt_O(cnt_b)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a level is accepted once the last FILTER_LEN synchronised
  // samples, all taken after the previous acceptance, differ from it.
  logic hist  [2][3][16];
  logic mlvl  [2][3];
  int   medge [2];
  int   macc  [2][3];
  int   mrise [2][3];
  int   mfall [2][3];
  int   mcnt  [2][3];

  function automatic int sp(input int d); return (d == 0) ? 2 : 0; endfunction
  function automatic int fp(input int d); return (d == 0) ? 3 : 1; endfunction
  function automatic int tp(input int d); return (d == 0) ? 1 : 4; endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      medge[d] = 0;
      for (int c = 0; c < 3; c++) begin
        for (int j = 0; j < 16; j++) hist[d][c][j] = 1'b0;
        mlvl[d][c]  = 1'b0;
        macc[d][c]  = -1000;
        mrise[d][c] = -1000;
        mfall[d][c] = -1000;
        mcnt[d][c]  = 0;
      end
    end
  endtask

  task automatic model_step(input int d, input logic [2:0] v, input logic clr);
    bit ok;
    medge[d]++;
    for (int c = 0; c < 3; c++) begin
      for (int j = 15; j > 0; j--) hist[d][c][j] = hist[d][c][j-1];
      hist[d][c][0] = v[c];
      ok = 1'b1;
      for (int j = 0; j < fp(d); j++)
        if (hist[d][c][sp(d)+j] == mlvl[d][c] || medge[d] - j <= macc[d][c]) ok = 1'b0;
      if (ok) begin
        mlvl[d][c] = !mlvl[d][c];
        macc[d][c] = medge[d];
        if (mlvl[d][c]) mrise[d][c] = medge[d];
        else            mfall[d][c] = medge[d];
      end
      if (clr)                    mcnt[d][c] = 0;
      else if (ok && mcnt[d][c] < 255) mcnt[d][c]++;
    end
  endtask

  task automatic compare_all();
    logic [2:0] el, ep, en;
`ifdef PULSE_GEN_EDGE_CNT_EN
    logic [23:0] ec;
`endif
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 3; c++) begin
        el[c] = mlvl[d][c];
        ep[c] = (medge[d] - mrise[d][c]) < tp(d);
        en[c] = (medge[d] - mfall[d][c]) < tp(d);
`ifdef PULSE_GEN_EDGE_CNT_EN
        ec[c*8 +: 8] = 8'(mcnt[d][c]);
`endif
      end
      if (d == 0) begin
        chk("a_level", lvl_a, el);
        chk("a_pos", pos_a, ep);
        chk("a_neg", neg_a, en);
        chk("a_toggle", tog_a, ep | en);
`ifdef PULSE_GEN_EDGE_CNT_EN
        chk("a_cnt", cnt_a, ec);
`endif
      end else begin
        chk("b_level", lvl_b, el);
        chk("b_pos", pos_b, ep);
        chk("b_neg", neg_b, en);
        chk("b_toggle", tog_b, ep | en);
`ifdef PULSE_GEN_EDGE_CNT_EN
        chk("b_cnt", cnt_b, ec);
`endif
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0, in_a, clr_a);
      model_step(1, in_b, clr_b);
    end
    #1;
    if (rst_n) compare_all();
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_a"}, {lvl_a, tog_a, pos_a, neg_a}, 12'h000);
    chk({nm, "_b"}, {lvl_b, tog_b, pos_b, neg_b}, 12'h000);
  endtask

  initial begin
    rst_n = 1'b0;
    in_a  = 3'b000;
    in_b  = 3'b000;
    clr_a = 1'b0;
    clr_b = 1'b0;
    wait_edges(2);
    chk_all_zero("reset_state");
    @(negedge clk) rst_n = 1'b1;
    wait_edges(3);

    // Default latency: level and one-cycle posedge pulse on the 5th edge
    @(negedge clk) in_a[0] = 1'b1;
    wait_edges(4);
    chk("t1_level_P3", lvl_a[0], 1'b0);
    wait_edges(1);
    chk("t1_level_P4", lvl_a[0], 1'b1);
    chk("t1_pos_P4", pos_a[0], 1'b1);
    chk("t1_tog_P4", tog_a[0], 1'b1);
    chk("t1_neg_P4", neg_a[0], 1'b0);
    chk("t1_model_P4", mlvl[0][0], 1'b1);
    wait_edges(1);
    chk("t1_pos_P5", pos_a[0], 1'b0);
    chk("t1_level_P5", lvl_a[0], 1'b1);
    @(negedge clk) in_a[0] = 1'b0;
    wait_edges(8);

    // Two-cycle glitch is rejected
    @(negedge clk) in_a[1] = 1'b1;
    @(negedge clk);
    @(negedge clk) in_a[1] = 1'b0;
    wait_edges(8);
    chk("t2_glitch_level", lvl_a[1], 1'b0);

    // Three-cycle high is accepted: level high three cycles
    @(negedge clk) in_a[1] = 1'b1;
    wait_edges(3);
    @(negedge clk) in_a[1] = 1'b0;
    wait_edges(2);
    chk("t2_level_P4", lvl_a[1], 1'b1);
    chk("t2_pos_P4", pos_a[1], 1'b1);
    wait_edges(2);
    chk("t2_level_P6", lvl_a[1], 1'b1);
    chk("t2_pulses_P6", {pos_a[1], neg_a[1]}, 2'b00);
    wait_edges(1);
    chk("t2_level_P7", lvl_a[1], 1'b0);
    chk("t2_neg_P7", neg_a[1], 1'b1);
    wait_edges(4);

    // Unsynchronised, unfiltered channel with four-cycle stretch
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) in_b[2] = (i < 2);
      @(posedge clk);
      #2;
      chk("t3_pos", pos_b[2], (i <= 3));
      chk("t3_neg", neg_b[2], (i >= 2 && i <= 5));
      chk("t3_tog", tog_b[2], (i <= 5));
    end

    // Retrigger while the rise counter is at 2
    for (int i = 0; i < 9; i++) begin
      @(negedge clk) in_b[0] = (i == 0 || i >= 3);
      @(posedge clk);
      #2;
      chk("t4_pos", pos_b[0], (i <= 6));
      chk("t4_neg", neg_b[0], (i >= 1 && i <= 4));
    end
    wait_edges(3);

    // Reset mid-stretch clears everything at once
    @(negedge clk) in_b[1] = 1'b1;
    wait_edges(2);
    chk("t5_pos_before_rst", pos_b[1], 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("t5_async_rst");
    @(negedge clk) begin in_a = 3'b111; in_b = 3'b111; end
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_edges(1);
    chk("t5_b_pos_P0", pos_b, 3'b111);
    wait_edges(3);
    chk("t5_a_pos_P3", pos_a, 3'b000);
    chk("t5_a_level_P3", lvl_a, 3'b000);
    wait_edges(1);
    chk("t5_a_pos_P4", pos_a, 3'b111);
    chk("t5_a_level_P4", lvl_a, 3'b111);
    chk("t5_b_pos_P4", pos_b, 3'b000);
    wait_edges(1);
    chk("t5_a_pos_P5", pos_a, 3'b000);

`ifdef PULSE_GEN_EDGE_CNT_EN
    // Saturation after 300 accepted edges, then clear beats a coincident edge
    @(negedge clk) clr_b = 1'b1;
    @(negedge clk) clr_b = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk) in_b[0] = ~in_b[0];
    end
    wait_edges(1);
    chk("t6_cnt_sat", cnt_b[7:0], 8'd255);
    chk("t6_model_sat", mcnt[1][0], 255);
    @(negedge clk) begin clr_b = 1'b1; in_b[0] = ~in_b[0]; end
    wait_edges(1);
    chk("t6_cnt_clr", cnt_b[7:0], 8'd0);
    @(negedge clk) begin clr_b = 1'b0; in_b[0] = ~in_b[0]; end
    wait_edges(1);
    chk("t6_cnt_one", cnt_b[7:0], 8'd1);
`endif

    wait_edges(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_pulse_gen.md
Name: edge_pulse_gen

Overview:
- Parametrised successor to the per-bit toggle/posedge/negedge pulse generator.
- Per channel: optional input synchroniser, glitch filter (minimum stable time), filtered level output, and edge pulses stretched to a programmable width.
- Used in the HDMI output core to turn asynchronous or bouncy control levels (hotplug, mode strobes, sync flags) into clean single-clock-domain events.

Parameters:
- NUM, 3, number of independent channels.
- SYNC_STAGES, 2, synchroniser flops per channel. 0 = input used directly. Legal range 0..4.
- FILTER_LEN, 3, consecutive cycles a new level must persist before acceptance. Must be >= 1.
- STRETCH, 1, width in cycles of each edge pulse. Must be >= 1.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in  in  NUM  raw channel inputs; may be asynchronous when SYNC_STAGES >= 2.
- level_O  out  NUM  filtered, accepted level per channel.
- toggle_O  out  NUM  stretched pulse on either accepted edge.
- posedge_O  out  NUM  stretched pulse on accepted 0->1.
- negedge_O  out  NUM  stretched pulse on accepted 1->0.
- clr_I  in  1  (only with PULSE_GEN_EDGE_CNT_EN) synchronous clear of edge counters.
- edge_cnt_O  out  NUM*8  (only with PULSE_GEN_EDGE_CNT_EN) per-channel edge counts; channel i at bits [8i+7:8i].

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - sync flops, level L, filter counter, stretch counters all cleared to 0.
  - All outputs are 0 while reset is held.
- Reset mid-operation: any pulse in progress is aborted; there is no resume.
- Reset release with in=1: treated as a normal 0->1 change, so one posedge pulse fires after the nominal latency.
- Synchroniser: s = last stage of the SYNC_STAGES shift chain; when SYNC_STAGES=0, s = in combinationally.
- Filter, per channel, with counter fc of width clog2(FILTER_LEN), minimum 1. Each rising edge:
  - if s == L: fc <= 0;
  - else if fc == FILTER_LEN-1: L <= s, fc <= 0, edge event fires;
  - else: fc <= fc+1.
  - Any return of s to L before acceptance resets fc; partial counts never accumulate across glitches.
- Latency: an input change set up before rising edge P0 updates level_O on the (SYNC_STAGES+FILTER_LEN)-th rising edge, counting P0 as the 1st.
- Stretch: separate pc and nc counters per channel, each clog2(STRETCH+1) bits.
  - On a rise event, pc <= STRETCH. Otherwise pc decrements while nonzero.
  - nc behaves identically for fall events.
  - posedge_O = (pc != 0), negedge_O = (nc != 0), both registered-equivalent with no combinational path from in when SYNC_STAGES >= 1.
  - posedge_O/negedge_O rise on the same edge that L changes.
  - A new event while its counter is nonzero reloads it to STRETCH (retrigger; no counting of queued events).
  - posedge_O and negedge_O may overlap.
- toggle_O = posedge_O | negedge_O.
- Channels are fully independent; simultaneous events on multiple channels are all reported.

Optional Feature:
- Macro PULSE_GEN_EDGE_CNT_EN.
- Defined:
  - Adds clr_I and edge_cnt_O.
  - Each channel has an 8-bit counter that increments on every accepted edge (rise or fall) and saturates at 255.
  - Counter resets to 0 on rst_n low.
  - clr_I high: counter <= 0 on that edge, with clr taking priority over a same-cycle increment.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package edge_pulse_pkg holds:
  - constant function clog2;
  - EDGE_CNT_W = 8;
  - parameter-legality limits (SYNC_STAGES_MAX = 4).
- Sub-module edge_pulse_chan implements one channel (sync, filter, stretch, optional counter).
- The top generates NUM instances and concatenates outputs.
- Illegal parameters trigger a $error at elaboration.

Test Plan:
- Defaults (SYNC 2, FILTER 3, STRETCH 1): in[0] 0->1 before P0 and held → level_O[0] high after P4; posedge_O[0] and toggle_O[0] high for exactly the P4–P5 cycle; negedge_O[0] stays 0.
- Defaults: in[1] high for 2 cycles then low → no level or pulse change. in[1] high for 3 cycles → level_O[1] high 3 cycles; one posedge pulse followed 3 cycles later by one negedge pulse.
- SYNC 0, FILTER 1, STRETCH 4: in[2] rises before P0 and falls before P2 → posedge_O[2] high P0–P4, negedge_O[2] high P2–P6, toggle_O[2] high continuously P0–P6.
- STRETCH 4: second rise accepted while pc = 2 → pc reloads; posedge_O stays high 4 cycles past the second event.
- rst_n pulled low mid-stretch between edges → all outputs 0 immediately. Release with in=3'b111 → posedge_O = 3'b111 for one cycle after nominal latency.
- With PULSE_GEN_EDGE_CNT_EN: 300 clean toggles on in[0] → edge_cnt_O[7:0] = 255. clr_I coincident with an edge → 0.
